// File: rtl/ec_pkg.sv
// ---------------------------------------------------------------------------
// ec_pkg: shared state encoding, secp256k1 prime and modular add/sub, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ec_pkg;

  localparam int MAX_W = 256;

  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [3:0] {
    IDLE, CLASSIFY, NUM, DEN, INV_SQ, INV_MUL, SLOPE, XCALC, YCALC, DONE
  } ec_state_e;

  // Narrower fields are zero-extended to MAX_W by callers; unused upper bits prune away.
  function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [MAX_W-1:0] p);
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] mod_sub(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [MAX_W-1:0] p);
    if (a >= b) return a - b;
    return a - b + p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_mul_serial.sv
// ---------------------------------------------------------------------------
// mod_mul_serial: MSB-first interleaved shift-add modular multiplier, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_mul_serial
  import ec_pkg::*;
#(
  parameter int             W = 256,
  parameter logic [W-1:0]   P = SECP256K1_P[W-1:0]
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [MAX_W-1:0] r;
    r = mod_add(MAX_W'(x), MAX_W'(y), MAX_W'(P));
    return r[W-1:0];
  endfunction

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    step   = madd(acc_q, acc_q);
    if (b_q[W-1]) step = madd(step, a_q);
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = step;
      b_d   = b_q << 1;
      cnt_d = cnt_q - CW'(1);
      // Last step lands in the same edge that raises done: W+1 cycles after start.
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

`default_nettype wire

// File: rtl/ec_point_add_seq.sv
// ---------------------------------------------------------------------------
// ec_point_add_seq: sequential GF(P) Weierstrass point add/double, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ec_point_add_seq
  import ec_pkg::*;
#(
  parameter int           W = 256,
  parameter logic [W-1:0] P = SECP256K1_P[W-1:0],
  parameter logic [W-1:0] A = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic         a_inf,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic         b_inf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] outx,
  output logic [W-1:0] outy,
  output logic         out_inf
);

  localparam int           BW  = $clog2(W);
  localparam logic [W-1:0] TWO = W'(2);
  localparam logic [W-1:0] EXP = P - TWO;

  ec_state_e     state_q, state_d;
  logic [W-1:0]  ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic          a_inf_q, a_inf_d, b_inf_q, b_inf_d, dbl_q, dbl_d;
  logic [W-1:0]  num_q, num_d, den_q, den_d, acc_q, acc_d, s_q, s_d, x3_q, x3_d;
  logic [W-1:0]  outx_q, outx_d, outy_q, outy_d;
  logic          out_inf_q, out_inf_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          mul_wait_q, mul_wait_d;

  logic          mul_start, mul_done, mul_state, mul_fin;
  logic [W-1:0]  mul_a, mul_b, mul_p;

  function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [MAX_W-1:0] r;
    r = mod_add(MAX_W'(x), MAX_W'(y), MAX_W'(P));
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] msub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [MAX_W-1:0] r;
    r = mod_sub(MAX_W'(x), MAX_W'(y), MAX_W'(P));
    return r[W-1:0];
  endfunction

  mod_mul_serial #(.W(W), .P(P)) u_mul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    state_d    = state_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    bx_d       = bx_q;
    by_d       = by_q;
    a_inf_d    = a_inf_q;
    b_inf_d    = b_inf_q;
    dbl_d      = dbl_q;
    num_d      = num_q;
    den_d      = den_q;
    acc_d      = acc_q;
    s_d        = s_q;
    x3_d       = x3_q;
    outx_d     = outx_q;
    outy_d     = outy_q;
    out_inf_d  = out_inf_q;
    bit_d      = bit_q;
    mul_wait_d = mul_wait_q;
    mul_start  = 1'b0;
    mul_a      = acc_q;
    mul_b      = acc_q;

    // Every multiplying state issues one start, then waits for the done pulse.
    mul_state = (state_q inside {INV_SQ, INV_MUL, SLOPE, XCALC, YCALC}) ||
                (state_q == NUM && dbl_q);
    mul_fin   = mul_state && mul_wait_q && mul_done;
    if (mul_state) begin
      if (!mul_wait_q) begin
        mul_start  = 1'b1;
        mul_wait_d = 1'b1;
      end else if (mul_done) begin
        mul_wait_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ax_d    = ax;
          ay_d    = ay;
          bx_d    = bx;
          by_d    = by;
          a_inf_d = a_inf;
          b_inf_d = b_inf;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        state_d = DONE;
        if (a_inf_q) begin
          outx_d    = b_inf_q ? '0 : bx_q;
          outy_d    = b_inf_q ? '0 : by_q;
          out_inf_d = b_inf_q;
        end else if (b_inf_q) begin
          outx_d    = ax_q;
          outy_d    = ay_q;
          out_inf_d = 1'b0;
        end else if (ax_q == bx_q && (ay_q != by_q || ay_q == '0)) begin
          outx_d    = '0;
          outy_d    = '0;
          out_inf_d = 1'b1;
        end else begin
          dbl_d   = (ax_q == bx_q);
          state_d = NUM;
        end
      end
      NUM: begin
        mul_a = ax_q;
        mul_b = ax_q;
        if (!dbl_q) begin
          num_d   = msub(by_q, ay_q);
          state_d = DEN;
        end else if (mul_fin) begin
          num_d   = madd(madd(madd(mul_p, mul_p), mul_p), A);
          state_d = DEN;
        end
      end
      DEN: begin
        den_d   = dbl_q ? madd(ay_q, ay_q) : msub(bx_q, ax_q);
        acc_d   = W'(1);
        bit_d   = BW'(W - 1);
        state_d = INV_SQ;
      end
      INV_SQ: begin
        if (mul_fin) begin
          acc_d = mul_p;
          if (EXP[bit_q])            state_d = INV_MUL;
          else if (bit_q == '0)      state_d = SLOPE;
          else                       bit_d   = bit_q - BW'(1);
        end
      end
      INV_MUL: begin
        mul_b = den_q;
        if (mul_fin) begin
          acc_d = mul_p;
          if (bit_q == '0) begin
            state_d = SLOPE;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = INV_SQ;
          end
        end
      end
      SLOPE: begin
        mul_a = num_q;
        if (mul_fin) begin
          s_d     = mul_p;
          state_d = XCALC;
        end
      end
      XCALC: begin
        mul_a = s_q;
        mul_b = s_q;
        if (mul_fin) begin
          x3_d    = msub(msub(mul_p, ax_q), bx_q);
          state_d = YCALC;
        end
      end
      YCALC: begin
        mul_a = s_q;
        mul_b = msub(ax_q, x3_q);
        if (mul_fin) begin
          outx_d    = x3_q;
          outy_d    = msub(mul_p, ay_q);
          out_inf_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      ax_q       <= '0;
      ay_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      a_inf_q    <= 1'b0;
      b_inf_q    <= 1'b0;
      dbl_q      <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      acc_q      <= '0;
      s_q        <= '0;
      x3_q       <= '0;
      outx_q     <= '0;
      outy_q     <= '0;
      out_inf_q  <= 1'b0;
      bit_q      <= '0;
      mul_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      a_inf_q    <= a_inf_d;
      b_inf_q    <= b_inf_d;
      dbl_q      <= dbl_d;
      num_q      <= num_d;
      den_q      <= den_d;
      acc_q      <= acc_d;
      s_q        <= s_d;
      x3_q       <= x3_d;
      outx_q     <= outx_d;
      outy_q     <= outy_d;
      out_inf_q  <= out_inf_d;
      bit_q      <= bit_d;
      mul_wait_q <= mul_wait_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign outx      = outx_q;
  assign outy      = outy_q;
  assign out_inf   = out_inf_q;

  a_operand_range: assert property (@(posedge Clk) disable iff (!Reset)
    (in_valid && in_ready) |->
      ((a_inf || (ax < P && ay < P)) && (b_inf || (bx < P && by < P))));

endmodule

`default_nettype wire

// File: tb/tb_ec_point_add_seq.sv
// ---------------------------------------------------------------------------
// tb_ec_point_add_seq: directed checks on a GF(17) instance and secp256k1, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ec_point_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // GF(17), A=2 instance
  logic       rst8_n, iv8, ir8, ai8, bi8, ov8, or8, oi8;
  logic [7:0] ax8, ay8, bx8, by8, ox8, oy8;

  // secp256k1 instance
  logic         rst256_n, iv256, ir256, ai256, bi256, ov256, or256, oi256;
  logic [255:0] ax256, ay256, bx256, by256, ox256, oy256;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

  ec_point_add_seq #(.W(8), .P(8'd17), .A(8'd2)) dut8 (
    .Clk(clk), .Reset(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .ax(ax8), .ay(ay8), .a_inf(ai8), .bx(bx8), .by(by8), .b_inf(bi8),
    .out_valid(ov8), .out_ready(or8), .outx(ox8), .outy(oy8), .out_inf(oi8)
  );

  ec_point_add_seq #(.W(256), .A(256'd0)) dut256 (
    .Clk(clk), .Reset(rst256_n), .in_valid(iv256), .in_ready(ir256),
    .ax(ax256), .ay(ay256), .a_inf(ai256), .bx(bx256), .by(by256), .b_inf(bi256),
    .out_valid(ov256), .out_ready(or256), .outx(ox256), .outy(oy256), .out_inf(oi256)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request from a negedge; returns #1 after the accepting edge.
  task automatic issue8(input logic [7:0] xa, input logic [7:0] ya, input logic ia,
                        input logic [7:0] xb, input logic [7:0] yb, input logic ib);
    @(negedge clk);
    ax8 = xa; ay8 = ya; ai8 = ia; bx8 = xb; by8 = yb; bi8 = ib; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
  endtask

  task automatic wait8(input string tag);
    int cyc = 0;
    while (!ov8 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, ov8, 1'b1);
  endtask

  task automatic accept8(input string tag);
    @(negedge clk) or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check(tag, {ov8, ir8}, 2'b01);
  endtask

  task automatic result8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic inf);
    check({tag, "_x"}, ox8, x);
    check({tag, "_y"}, oy8, y);
    check({tag, "_inf"}, oi8, inf);
  endtask

  initial begin
    rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    ax8 = '0; ay8 = '0; bx8 = '0; by8 = '0; ai8 = 1'b0; bi8 = 1'b0;
    rst256_n = 1'b0; iv256 = 1'b0; or256 = 1'b0;
    ax256 = '0; ay256 = '0; bx256 = '0; by256 = '0; ai256 = 1'b0; bi256 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ov8, 1'b0);
    check("rst_ready", ir8, 1'b1);
    check("rst_out", {ox8, oy8, oi8}, 17'd0);
    check("rst256_valid", ov256, 1'b0);
    @(negedge clk);
    rst8_n = 1'b1; rst256_n = 1'b1;

    fork
      begin : secp_branch
        int cyc = 0;
        @(negedge clk);
        ax256 = GX; ay256 = GY; bx256 = GX; by256 = GY; iv256 = 1'b1;
        @(posedge clk);
        #1 iv256 = 1'b0;
        while (!ov256 && cyc < 140000) begin
          @(posedge clk); #1;
          cyc++;
        end
        check("g2_valid", ov256, 1'b1);
        check("g2_x", ox256, G2X);
        check("g2_y", oy256, G2Y);
        check("g2_inf", oi256, 1'b0);
      end
      begin : gf17_branch
        logic [16:0] snap;
        logic        stable;

        issue8(8'd5, 8'd1, 1'b0, 8'd6, 8'd3, 1'b0);
        wait8("add_valid");
        result8("add", 8'd10, 8'd6, 1'b0);
        accept8("add_done");

        issue8(8'd5, 8'd1, 1'b0, 8'd5, 8'd1, 1'b0);
        wait8("dbl_valid");
        result8("dbl", 8'd6, 8'd3, 1'b0);
        accept8("dbl_done");

        // P == -Q: result appears two cycles after the accepting cycle
        issue8(8'd5, 8'd1, 1'b0, 8'd5, 8'd16, 1'b0);
        check("neg_classify", ov8, 1'b0);
        @(posedge clk); #1;
        check("neg_valid", ov8, 1'b1);
        result8("neg", 8'd0, 8'd0, 1'b1);
        accept8("neg_done");

        // out_ready already high as out_valid rises
        @(negedge clk) or8 = 1'b1;
        issue8(8'd0, 8'd0, 1'b1, 8'd6, 8'd3, 1'b0);
        @(posedge clk); #1;
        check("ainf_valid", ov8, 1'b1);
        result8("ainf", 8'd6, 8'd3, 1'b0);
        @(posedge clk); #1;
        or8 = 1'b0;
        check("ainf_same_cycle_accept", {ov8, ir8}, 2'b01);

        // backpressure
        issue8(8'd5, 8'd1, 1'b0, 8'd6, 8'd3, 1'b0);
        wait8("bp_valid");
        snap = {ox8, oy8, oi8};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          if ({ox8, oy8, oi8} !== snap || ov8 !== 1'b1 || ir8 !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        result8("bp", 8'd10, 8'd6, 1'b0);
        accept8("bp_done");
        issue8(8'd5, 8'd1, 1'b0, 8'd5, 8'd16, 1'b0);
        @(posedge clk); #1;
        check("bp_next", {ov8, oi8}, 2'b11);
        accept8("bp_next_done");

        // reset in the middle of the inversion of a doubling
        issue8(8'd5, 8'd1, 1'b0, 8'd5, 8'd1, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk) rst8_n = 1'b0;
        #1;
        check("mid_rst_state", {ov8, ir8, ox8, oy8, oi8}, 19'h20000);
        @(negedge clk);
        @(negedge clk) rst8_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_stale", ov8, 1'b0);
        issue8(8'd5, 8'd1, 1'b0, 8'd6, 8'd3, 1'b0);
        wait8("post_rst_valid");
        result8("post_rst", 8'd10, 8'd6, 1'b0);
        accept8("post_rst_done");
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ec_point_add_seq.md
Name: ec_point_add_seq

Overview:
- Sequential elliptic-curve point adder/doubler over GF(P), short Weierstrass curve y^2 = x^3 + A*x + B.
- Parametrised successor to the combinational slope-in point op. It computes the slope itself, including the modular inverse (Fermat), and reduces every intermediate mod P.
- Handles the point-at-infinity and P == -Q cases, and switches automatically between add and double.
- Sits between the scalar-multiply controller and the operand register file; it shares one bit-serial modular multiplier.

Parameters:
- W, 256, coordinate/field width in bits.
- P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field prime; must satisfy P < 2^W.
- A, 0, curve coefficient a; used only for doubling; must be < P.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- ax, ay  in  W  point A; values must be < P.
- a_inf  in  1  A is the point at infinity.
- bx, by  in  W  point B; values must be < P.
- b_inf  in  1  B is the point at infinity.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- outx, outy  out  W  result coordinates, fully reduced (< P).
- out_inf  out  1  result is the point at infinity; outx/outy are 0 when set.

Behaviour:
- Reset (async, Reset=0): state IDLE; out_valid=0; outx=outy=0; out_inf=0; multiplier aborted. in_ready=1 once in IDLE. Reset mid-operation discards the operation with no output.
- Accept: in_valid && in_ready latches operands and moves to CLASSIFY. Operands are not sampled in any other state.
- CLASSIFY (1 cycle) selects one of these results:
  - a_inf: result = B.
  - else b_inf: result = A.
  - else ax==bx && ay!=by: result = infinity.
  - else ax==bx && ay==0: result = infinity.
  - else ax==bx: doubling path.
  - otherwise: add path.
- Trivial results go straight to DONE, 2 cycles after accept.
- Add path: num = by-ay; den = bx-ax.
- Double path: num = 3*ax^2 + A; den = 2*ay.
  - ax^2 uses the multiplier.
  - 3x and 2y are formed by chained modular additions.
- INV: inv = den^(P-2), left-to-right square-and-multiply over all W bits of P-2.
  - acc starts at 1.
  - Per bit: square, then multiply by den if the bit is 1.
  - A bit counter runs from W-1 down to 0.
- SLOPE: s = num*inv.
- X: x3 = s*s - ax - bx.
- Y: y3 = s*(ax - x3) - ay.
- Then DONE.
- Modular add: (a+b) computed at W+1 bits; subtract P if the sum >= P.
- Modular sub: a-b if a>=b, else a-b+P.
- All results are < P given inputs < P.
- Multiplier: interleaved shift-add with per-step reduction.
  - Start pulse; result valid with a done pulse exactly W+1 cycles later.
  - One multiply in flight at a time.
- DONE: out_valid=1; outx/outy/out_inf are stable. On out_valid && out_ready, return to IDLE (out_valid falls next cycle).
  - in_ready stays 0 during DONE, so no back-to-back overlap.
- Latency is deterministic for fixed P. Non-trivial result = fixed FSM overhead + (number of multiplies)*(W+1). Multiplies = 1 (double only) + W + popcount(P-2) + 3.
- Simultaneous out_ready in the same cycle out_valid rises counts as an accept.
- Operands >= P: behaviour unspecified; flagged by a simulation assertion.

Decomposition:
- Package ec_pkg holds:
  - state enum: IDLE, CLASSIFY, NUM, DEN, INV_SQ, INV_MUL, SLOPE, XCALC, YCALC, DONE.
  - secp256k1 P constant.
  - mod_add and mod_sub functions, parametrised by width via the class-parameter idiom or fixed W.
- Sub-module mod_mul_serial (W, P): Clk, Reset, start, a, b, done, p. Instantiated once and time-shared by the FSM.

Test Plan:
- W=8, P=17, A=2; add (5,1)+(6,3) -> out (10,6), out_inf=0.
- Same params; double (5,1)+(5,1) -> (6,3). Also checks 3x^2+A = 77 ≡ 9 and inv(2) = 9.
- Inverse case: (5,1)+(5,16) -> out_inf=1, outx=outy=0, 2 cycles after accept. Also a_inf=1 with B=(6,3) -> out (6,3).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0. Raise out_ready -> IDLE, next request accepted.
- Assert Reset=0 midway through INV of a double, then release and issue (5,1)+(6,3) -> no stale out_valid; correct (10,6).
- W=256 secp256k1 with A=0: double the generator G -> 2G = (C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A).
